// File: rtl/game_pkg.sv
// Shared types and constants for the N x N, K-in-a-row game controller.
//   - One-hot state encodings in {Qi,Qs,Qx,Qxw,Qo,Qow,Qd} bit order (MSB first)
//   - Cell encoding: 00 empty, 01 X, 10 O
package game_pkg;

  localparam int unsigned StateW = 7;

  localparam logic [StateW-1:0] QI  = 7'b1000000;
  localparam logic [StateW-1:0] QS  = 7'b0100000;
  localparam logic [StateW-1:0] QX  = 7'b0010000;
  localparam logic [StateW-1:0] QXW = 7'b0001000;
  localparam logic [StateW-1:0] QO  = 7'b0000100;
  localparam logic [StateW-1:0] QOW = 7'b0000010;
  localparam logic [StateW-1:0] QD  = 7'b0000001;

  typedef enum logic [StateW-1:0] {
    StIni  = QI,
    StSta  = QS,
    StXtu  = QX,
    StXck  = QXW,
    StOtu  = QO,
    StOck  = QOW,
    StDone = QD
  } state_e;

  typedef logic [1:0] cell_t;

  localparam cell_t EMPTY  = 2'b00;
  localparam cell_t MARK_X = 2'b01;
  localparam cell_t MARK_O = 2'b10;

endpackage

// File: rtl/nxn_game_ctrl_if.sv
// Move port of the game controller: valid/ready offer of a (row, col) target cell.
//   MoveValid  - move offered this cycle (front end -> controller)
//   MoveRow    - target row, $clog2(N) bits
//   MoveCol    - target column, $clog2(N) bits
//   MoveReady  - controller is waiting for a move (XTU/OTU)
//   MoveReject - one-cycle pulse after an illegal move
interface nxn_game_ctrl_if #(
  parameter int unsigned N = 3
);
  localparam int unsigned CW = $clog2(N);

  logic          MoveValid;
  logic [CW-1:0] MoveRow;
  logic [CW-1:0] MoveCol;
  logic          MoveReady;
  logic          MoveReject;

  modport master (
    output MoveValid, MoveRow, MoveCol,
    input  MoveReady, MoveReject
  );

  modport slave (
    input  MoveValid, MoveRow, MoveCol,
    output MoveReady, MoveReject
  );

endinterface

// File: rtl/kline_detect.sv
// Combinational K-in-a-row detector through one cell.
//   board_i - flattened board, cell (r,c) at [2*(r*N+c)+:2]
//   row_i   - row of the last move
//   col_i   - column of the last move
//   mark_i  - mark of the mover
//   win_o   - a run of >= K marks passes through (row_i, col_i)
module kline_detect
  import game_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic [2*N*N-1:0] board_i,
  input  logic [CW-1:0]    row_i,
  input  logic [CW-1:0]    col_i,
  input  cell_t            mark_i,
  output logic             win_o
);

  localparam int NI = int'(N);
  localparam int KI = int'(K);

  always_comb begin
    win_o = 1'b0;
    // Directions: 0 row, 1 column, 2 diagonal, 3 anti-diagonal.
    for (int d = 0; d < 4; d++) begin
      int dr;
      int dc;
      int run_len;
      dr      = (d == 0) ? 0 : 1;
      dc      = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      run_len = 1;
      // Walk backward (sgn=-1) then forward (sgn=+1) until the run breaks.
      for (int sgn = -1; sgn <= 1; sgn += 2) begin
        logic alive;
        alive = 1'b1;
        for (int s = 1; s < KI; s++) begin
          int r;
          int c;
          r = int'(row_i) + sgn * s * dr;
          c = int'(col_i) + sgn * s * dc;
          if (r < 0 || r >= NI || c < 0 || c >= NI) begin
            alive = 1'b0;
          end else if (alive && (board_i[2*(r*NI+c) +: 2] == mark_i)) begin
            run_len++;
          end else begin
            alive = 1'b0;
          end
        end
      end
      if (run_len >= KI) win_o = 1'b1;
    end
  end

endmodule

// File: rtl/nxn_game_ctrl.sv
// N x N, K-in-a-row two-player game engine with saturating per-player scores.
//   Clk, Reset   - clock and synchronous active-high reset
//   Start        - begin a round (INI only)
//   Ack          - acknowledge the result (DONE only)
//   mv           - move port (valid/ready, reject pulse)
//   Board        - flattened board, cell (r,c) at [2*(r*N+c)+:2]
//   State        - one-hot {Qi,Qs,Qx,Qxw,Qo,Qow,Qd}
//   Xwins/Owins/Draw - round result flags
//   P1s/P2s      - X and O scores
module nxn_game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned K       = 3,
  parameter int unsigned SCORE_W = 12
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Ack,
  nxn_game_ctrl_if.slave       mv,
  output logic [2*N*N-1:0]     Board,
  output logic [StateW-1:0]    State,
  output logic                 Xwins,
  output logic                 Owins,
  output logic                 Draw,
  output logic [SCORE_W-1:0]   P1s,
  output logic [SCORE_W-1:0]   P2s
);

  localparam int unsigned CW   = $clog2(N);
  localparam int unsigned CntW = $clog2(N*N+1);

  state_e             state_q;
  logic [2*N*N-1:0]   board_q;
  logic [CntW-1:0]    cnt_q;
  logic [CW-1:0]      last_row_q, last_col_q;
  logic               reject_q, xwins_q, owins_q, draw_q;
  logic [SCORE_W-1:0] p1_q, p2_q;

  logic        in_range, cell_empty, move_ok, x_turn, win, full;
  int unsigned cell_idx;
  cell_t       turn_mark;

  assign in_range   = (32'(mv.MoveRow) < N) && (32'(mv.MoveCol) < N);
  // Index forced to 0 when out of range so the part-select never leaves the board.
  assign cell_idx   = in_range ? (32'(mv.MoveRow) * N + 32'(mv.MoveCol)) : 32'd0;
  assign cell_empty = (board_q[2*cell_idx +: 2] == EMPTY);
  assign move_ok    = in_range && cell_empty;
  assign x_turn     = (state_q == StXtu) || (state_q == StXck);
  assign turn_mark  = x_turn ? MARK_X : MARK_O;
  assign full       = (cnt_q == CntW'(N*N));

  kline_detect #(
    .N (N),
    .K (K)
  ) u_kline_detect (
    .board_i (board_q),
    .row_i   (last_row_q),
    .col_i   (last_col_q),
    .mark_i  (turn_mark),
    .win_o   (win)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= StIni;
      board_q    <= '0;
      cnt_q      <= '0;
      last_row_q <= '0;
      last_col_q <= '0;
      reject_q   <= 1'b0;
      xwins_q    <= 1'b0;
      owins_q    <= 1'b0;
      draw_q     <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
    end else begin
      reject_q <= 1'b0;
      unique case (state_q)
        StIni: if (Start) state_q <= StSta;
        StSta: begin
          board_q <= '0;
          cnt_q   <= '0;
          xwins_q <= 1'b0;
          owins_q <= 1'b0;
          draw_q  <= 1'b0;
          state_q <= StXtu;
        end
        StXtu, StOtu: begin
          if (mv.MoveValid) begin
            if (move_ok) begin
              board_q[2*cell_idx +: 2] <= turn_mark;
              cnt_q      <= cnt_q + 1'b1;
              last_row_q <= mv.MoveRow;
              last_col_q <= mv.MoveCol;
              state_q    <= x_turn ? StXck : StOck;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        StXck, StOck: begin
          // Win is tested before the full-board check so a winning last move is a win.
          if (win) begin
            if (x_turn) begin
              xwins_q <= 1'b1;
              p1_q    <= (&p1_q) ? p1_q : p1_q + 1'b1;
            end else begin
              owins_q <= 1'b1;
              p2_q    <= (&p2_q) ? p2_q : p2_q + 1'b1;
            end
            state_q <= StDone;
          end else if (full) begin
            draw_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= x_turn ? StOtu : StXtu;
          end
        end
        StDone: if (Ack) state_q <= StIni;
        default: state_q <= StIni;
      endcase
    end
  end

  assign mv.MoveReady  = (state_q == StXtu) || (state_q == StOtu);
  assign mv.MoveReject = reject_q;
  assign Board         = board_q;
  assign State         = state_q;
  assign Xwins         = xwins_q;
  assign Owins         = owins_q;
  assign Draw          = draw_q;
  assign P1s           = p1_q;
  assign P2s           = p2_q;

endmodule

// File: tb/tb_nxn_game_ctrl.sv
// Directed bench for nxn_game_ctrl. Three instances share one stimulus bus;
// `sel` picks which one receives Start/Ack/MoveValid and whose outputs are checked.
//   dut 0: N=3 K=3 SCORE_W=12   dut 1: N=5 K=4 SCORE_W=12   dut 2: N=3 K=3 SCORE_W=2
module tb_nxn_game_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, ack, mv_valid;
  logic [2:0] mv_row, mv_col;
  int         sel;
  int         cur_n;

  always #5 clk = ~clk;

  nxn_game_ctrl_if #(.N(3)) if0 ();
  nxn_game_ctrl_if #(.N(5)) if1 ();
  nxn_game_ctrl_if #(.N(3)) if2 ();

  assign if0.MoveValid = mv_valid && (sel == 0);
  assign if0.MoveRow   = mv_row[1:0];
  assign if0.MoveCol   = mv_col[1:0];
  assign if1.MoveValid = mv_valid && (sel == 1);
  assign if1.MoveRow   = mv_row;
  assign if1.MoveCol   = mv_col;
  assign if2.MoveValid = mv_valid && (sel == 2);
  assign if2.MoveRow   = mv_row[1:0];
  assign if2.MoveCol   = mv_col[1:0];

  logic [17:0] board0, board2;
  logic [49:0] board1;
  logic [6:0]  state0, state1, state2;
  logic        xw0, ow0, dr0, xw1, ow1, dr1, xw2, ow2, dr2;
  logic [11:0] p1_0, p2_0, p1_1, p2_1;
  logic [1:0]  p1_2, p2_2;

  nxn_game_ctrl #(.N(3), .K(3), .SCORE_W(12)) dut0 (
    .Clk(clk), .Reset(rst), .Start(start && (sel == 0)), .Ack(ack && (sel == 0)), .mv(if0),
    .Board(board0), .State(state0), .Xwins(xw0), .Owins(ow0), .Draw(dr0),
    .P1s(p1_0), .P2s(p2_0)
  );

  nxn_game_ctrl #(.N(5), .K(4), .SCORE_W(12)) dut1 (
    .Clk(clk), .Reset(rst), .Start(start && (sel == 1)), .Ack(ack && (sel == 1)), .mv(if1),
    .Board(board1), .State(state1), .Xwins(xw1), .Owins(ow1), .Draw(dr1),
    .P1s(p1_1), .P2s(p2_1)
  );

  nxn_game_ctrl #(.N(3), .K(3), .SCORE_W(2)) nxn_game_ctrl_sat (
    .Clk(clk), .Reset(rst), .Start(start && (sel == 2)), .Ack(ack && (sel == 2)), .mv(if2),
    .Board(board2), .State(state2), .Xwins(xw2), .Owins(ow2), .Draw(dr2),
    .P1s(p1_2), .P2s(p2_2)
  );

  logic [63:0] o_board, o_p1, o_p2;
  logic [6:0]  o_state;
  logic        o_ready, o_reject, o_x, o_o, o_d;

  always_comb begin
    o_board = 64'(board0); o_state = state0; o_x = xw0; o_o = ow0; o_d = dr0;
    o_p1 = 64'(p1_0); o_p2 = 64'(p2_0); o_ready = if0.MoveReady; o_reject = if0.MoveReject;
    if (sel == 1) begin
      o_board = 64'(board1); o_state = state1; o_x = xw1; o_o = ow1; o_d = dr1;
      o_p1 = 64'(p1_1); o_p2 = 64'(p2_1); o_ready = if1.MoveReady; o_reject = if1.MoveReject;
    end else if (sel == 2) begin
      o_board = 64'(board2); o_state = state2; o_x = xw2; o_o = ow2; o_d = dr2;
      o_p1 = 64'(p1_2); o_p2 = 64'(p2_2); o_ready = if2.MoveReady; o_reject = if2.MoveReject;
    end
  end

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] mb;  // expected board

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_round();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("sta_state", 64'(o_state), 64'(QS));
    tick();
    check_eq("xtu_state", 64'(o_state), 64'(QX));
    check_eq("xtu_ready", 64'(o_ready), 64'd1);
    mb = '0;
  endtask

  task automatic end_round();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("ack_to_ini", 64'(o_state), 64'(QI));
  endtask

  // Accept edge then check edge; board compared against the bench's own board.
  task automatic play(input int r, input int c, input logic [1:0] m);
    mv_valid = 1'b1;
    mv_row   = 3'(r);
    mv_col   = 3'(c);
    tick();
    mv_valid = 1'b0;
    mb[2*(r*cur_n+c) +: 2] = m;
    tick();
    check_eq("board", o_board, mb);
  endtask

  task automatic offer_bad(input int r, input int c, input logic [6:0] st);
    mv_valid = 1'b1;
    mv_row   = 3'(r);
    mv_col   = 3'(c);
    tick();
    mv_valid = 1'b0;
    check_eq("bad_reject", 64'(o_reject), 64'd1);
    check_eq("bad_state", 64'(o_state), 64'(st));
    check_eq("bad_board", o_board, mb);
  endtask

  localparam logic [1:0] X = 2'b01;
  localparam logic [1:0] O = 2'b10;

  initial begin
    logic [63:0] exp_p1 [4];
    exp_p1 = '{64'd1, 64'd2, 64'd3, 64'd3};
    rst = 1'b1; start = 1'b0; ack = 1'b0; mv_valid = 1'b0; mv_row = '0; mv_col = '0;
    sel = 0; cur_n = 3; mb = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    check_eq("rst_state", 64'(o_state), 64'(QI));
    check_eq("rst_board", o_board, 64'd0);
    check_eq("rst_ready", 64'(o_ready), 64'd0);
    check_eq("rst_reject", 64'(o_reject), 64'd0);
    check_eq("rst_flags", 64'({o_x, o_o, o_d}), 64'd0);
    check_eq("rst_p1", o_p1, 64'd0);
    check_eq("rst_p2", o_p2, 64'd0);

    // MoveValid in INI has no effect
    mv_valid = 1'b1; mv_row = 3'd0; mv_col = 3'd0;
    tick();
    mv_valid = 1'b0;
    check_eq("ini_move_board", o_board, 64'd0);
    check_eq("ini_move_reject", 64'(o_reject), 64'd0);

    // X row win, with latency of the first move checked edge by edge
    begin_round();
    mv_valid = 1'b1; mv_row = 3'd0; mv_col = 3'd0;
    tick();
    mv_valid = 1'b0;
    check_eq("acc_state_xck", 64'(o_state), 64'(QXW));
    check_eq("acc_board", o_board, 64'd1);
    check_eq("xck_ready", 64'(o_ready), 64'd0);
    tick();
    check_eq("chk_state_otu", 64'(o_state), 64'(QO));
    mb = 64'd1;
    play(1, 0, O);
    play(0, 1, X);
    play(1, 1, O);
    mv_valid = 1'b1; mv_row = 3'd0; mv_col = 3'd2;
    tick();
    mv_valid = 1'b0;
    check_eq("win_not_yet", 64'(o_x), 64'd0);
    tick();
    check_eq("row_board", o_board, 64'd661);
    check_eq("row_xwins", 64'(o_x), 64'd1);
    check_eq("row_owins", 64'(o_o), 64'd0);
    check_eq("row_p1", o_p1, 64'd1);
    check_eq("row_state", 64'(o_state), 64'(QD));
    end_round();
    check_eq("ini_flag_hold", 64'(o_x), 64'd1);
    check_eq("ini_p1_hold", o_p1, 64'd1);

    // Draw: X O X / X O O / O X X
    begin_round();
    check_eq("sta_clears_x", 64'(o_x), 64'd0);
    play(0, 0, X); play(0, 1, O); play(0, 2, X); play(1, 1, O); play(1, 0, X);
    play(1, 2, O); play(2, 1, X); play(2, 0, O); play(2, 2, X);
    check_eq("draw_flag", 64'(o_d), 64'd1);
    check_eq("draw_xwins", 64'(o_x), 64'd0);
    check_eq("draw_state", 64'(o_state), 64'(QD));
    check_eq("draw_p1", o_p1, 64'd1);
    check_eq("draw_p2", o_p2, 64'd0);
    end_round();

    // 9th move completes the diagonal: X X O / O X O / X O X
    begin_round();
    check_eq("sta_clears_d", 64'(o_d), 64'd0);
    play(0, 0, X); play(0, 2, O); play(0, 1, X); play(1, 0, O); play(1, 1, X);
    play(1, 2, O); play(2, 0, X); play(2, 1, O); play(2, 2, X);
    check_eq("full_win_x", 64'(o_x), 64'd1);
    check_eq("full_win_draw", 64'(o_d), 64'd0);
    check_eq("full_win_p1", o_p1, 64'd2);
    end_round();

    // Illegal moves, then Reset while in OCK
    begin_round();
    play(1, 1, X);
    check_eq("ill_board", o_board, 64'd256);
    offer_bad(1, 1, QO);
    mv_valid = 1'b1;
    tick();
    check_eq("ill_held_reject", 64'(o_reject), 64'd1);
    mv_valid = 1'b0;
    tick();
    check_eq("ill_reject_end", 64'(o_reject), 64'd0);
    offer_bad(3, 0, QO);
    mv_valid = 1'b1; mv_row = 3'd0; mv_col = 3'd0;
    tick();
    mv_valid = 1'b0;
    check_eq("pre_rst_ock", 64'(o_state), 64'(QOW));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_state", 64'(o_state), 64'(QI));
    check_eq("mid_rst_board", o_board, 64'd0);
    check_eq("mid_rst_p1", o_p1, 64'd0);
    check_eq("mid_rst_flags", 64'({o_x, o_o, o_d, o_ready, o_reject}), 64'd0);

    // Start and Ack in XTU are ignored
    begin_round();
    start = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    check_eq("xtu_start_ign", 64'(o_state), 64'(QX));
    check_eq("xtu_start_board", o_board, 64'd0);

    // N=5 K=4: out-of-range rejects, 3-run no win, anti-diagonal O win with middle last
    sel = 1; cur_n = 5;
    begin_round();
    offer_bad(7, 0, QX);
    offer_bad(0, 5, QX);
    play(4, 0, X); play(3, 0, O); play(4, 1, X); play(2, 1, O); play(4, 2, X);
    check_eq("run3_no_win", 64'(o_x), 64'd0);
    check_eq("run3_state", 64'(o_state), 64'(QO));
    play(0, 3, O); play(0, 0, X); play(1, 2, O);
    check_eq("anti_owins", 64'(o_o), 64'd1);
    check_eq("anti_xwins", 64'(o_x), 64'd0);
    check_eq("anti_p2", o_p2, 64'd1);
    check_eq("anti_p1", o_p1, 64'd0);
    check_eq("anti_state", 64'(o_state), 64'(QD));
    end_round();

    // SCORE_W=2: P1s saturates at 3 and survives Ack/Start
    sel = 2; cur_n = 3;
    for (int i = 0; i < 4; i++) begin
      begin_round();
      play(0, 0, X); play(1, 0, O); play(0, 1, X); play(1, 1, O); play(0, 2, X);
      check_eq("sat_p1", o_p1, exp_p1[i]);
      check_eq("sat_state", 64'(o_state), 64'(QD));
      end_round();
      check_eq("sat_p1_hold", o_p1, exp_p1[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
